// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back, waits on the memory
// ready handshake, and latches the first fault (illegal opcode or bus timeout).
module mips_multicycle_ctrl #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Fault,
  output logic [1:0] FaultCode
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPE, S_ALUWB, S_BEQ, S_ADDIEX, S_ADDIWB, S_JUMP, S_FAULT
  } state_t;

  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_wait;
  logic [7:0] w_wait_next;
  logic       r_fault;
  logic [1:0] r_fault_code;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_fault_enter;
  logic [1:0] w_fault_code_next;
  logic [7:0] w_wait_limit;
  logic       w_timeout;

  // The wait that would bring the counter up to MEM_TIMEOUT is the last one
  // allowed; MemReady on that same cycle still completes the access.
  assign w_wait_limit = MEM_TIMEOUT - 8'd1;
  assign w_timeout    = (r_wait == w_wait_limit);

  assign Fault     = r_fault;
  assign FaultCode = r_fault_code;

  // State, wait counter and sticky fault registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_RESET;
      r_wait       <= 8'd0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      if (w_fault_enter) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_fault_code_next;
      end
    end
  end

  // Next-state and Moore outputs (FETCH write enables are gated by MemReady)
  always_comb begin
    w_state_next      = r_state;
    w_wait_next       = 8'd0;
    w_pcwrite         = 1'b0;
    w_branch          = 1'b0;
    w_fault_enter     = 1'b0;
    w_fault_code_next = 2'b00;
    MemReq            = 1'b0;
    MemWrite          = 1'b0;
    IorD              = 1'b0;
    IRWrite           = 1'b0;
    RegDst            = 1'b0;
    MemtoReg          = 1'b0;
    RegWrite          = 1'b0;
    ALUSrcA           = 1'b0;
    ALUSrcB           = 2'b00;
    ALUOp             = 2'b00;
    PCSrc             = 2'b00;
    PCEn              = 1'b0;

    case (r_state)
      S_RESET: w_state_next = S_FETCH;
      S_FETCH: begin
        MemReq  = 1'b1;
        ALUSrcB = 2'b01;
        if (MemReady) begin
          IRWrite      = 1'b1;
          w_pcwrite    = 1'b1;
          w_state_next = S_DECODE;
        end else if (w_timeout) begin
          w_state_next      = S_FAULT;
          w_fault_enter     = 1'b1;
          w_fault_code_next = FC_TIMEOUT;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          6'b100011, 6'b101011: w_state_next = S_MEMADR;
          6'b000000:            w_state_next = S_RTYPE;
          6'b000100:            w_state_next = S_BEQ;
          6'b001000:            w_state_next = S_ADDIEX;
          6'b000010:            w_state_next = S_JUMP;
          default: begin
            w_state_next      = S_FAULT;
            w_fault_enter     = 1'b1;
            w_fault_code_next = FC_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        w_state_next = (Op == 6'b100011) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemReq = 1'b1;
        IorD   = 1'b1;
        if (MemReady) begin
          w_state_next = S_MEMWB;
        end else if (w_timeout) begin
          w_state_next      = S_FAULT;
          w_fault_enter     = 1'b1;
          w_fault_code_next = FC_TIMEOUT;
        end
      end
      S_MEMWB: begin
        RegWrite     = 1'b1;
        MemtoReg     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWR: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          w_state_next = S_FETCH;
        end else if (w_timeout) begin
          w_state_next      = S_FAULT;
          w_fault_enter     = 1'b1;
          w_fault_code_next = FC_TIMEOUT;
        end
      end
      S_RTYPE: begin
        ALUSrcA      = 1'b1;
        ALUOp        = 2'b10;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite     = 1'b1;
        RegDst       = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA      = 1'b1;
        ALUOp        = 2'b01;
        PCSrc        = 2'b01;
        w_branch     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        w_state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_JUMP: begin
        PCSrc        = 2'b10;
        w_pcwrite    = 1'b1;
        w_state_next = S_FETCH;
      end
      S_FAULT: w_state_next = S_FAULT;
      default: w_state_next = S_RESET;
    endcase

    PCEn = w_pcwrite | (w_branch & Zero);

    // Count only while the same access keeps waiting; any transition or ready clears it
    if (MemReq && !MemReady && (w_state_next == r_state)) begin
      w_wait_next = r_wait + 8'd1;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: an instruction-level
// microstep model compared every cycle, plus directed literal checks.
module tb_mips_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 15;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic       mreq;
    logic       mwr;
    logic       iord;
    logic       irw;
    logic       regdst;
    logic       m2r;
    logic       regw;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       fault;
    logic [1:0] code;
  } ctl_t;

  logic       CLK;
  logic       RST;
  logic [5:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       MemReq, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, Fault;
  logic [1:0] FaultCode;
  ctl_t       dut_c;

  int n_checks = 0;
  int n_errors = 0;
  int cycle_no = 0;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(8'(MEM_TIMEOUT))) dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .Fault(Fault), .FaultCode(FaultCode)
  );

  assign dut_c = {MemReq, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSrc, PCEn, Fault, FaultCode};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- instruction-level model ----------------
  // An instruction is a list of microsteps: 0 = fetch, 1 = decode, 2.. = execute.
  // Its length equals its latency with no memory waits.
  localparam int C_R = 0, C_ADDI = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_J = 5;

  bit       m_valid = 0;
  bit       m_rst   = 1;
  bit       m_fault = 0;
  bit [1:0] m_code  = 0;
  int       m_step  = 0;
  int       m_cls   = C_R;
  int       m_wait  = 0;

  function automatic int instr_len(input int cls);
    case (cls)
      C_LW:         return 5;
      C_BEQ, C_J:   return 3;
      default:      return 4;
    endcase
  endfunction

  function automatic ctl_t model_out();
    ctl_t c = '0;
    if (m_rst) return c;
    if (m_fault) begin
      c.fault = 1'b1;
      c.code  = m_code;
      return c;
    end
    if (m_step == 0) begin
      c.mreq = 1; c.srcb = 2'b01; c.irw = MemReady; c.pcen = MemReady;
    end else if (m_step == 1) begin
      c.srcb = 2'b11;
    end else begin
      case (m_cls)
        C_R:    if (m_step == 2) begin c.srca = 1; c.aluop = 2'b10; end
                else begin c.regw = 1; c.regdst = 1; end
        C_ADDI: if (m_step == 2) begin c.srca = 1; c.srcb = 2'b10; end
                else c.regw = 1;
        C_LW:   if (m_step == 2) begin c.srca = 1; c.srcb = 2'b10; end
                else if (m_step == 3) begin c.mreq = 1; c.iord = 1; end
                else begin c.regw = 1; c.m2r = 1; end
        C_SW:   if (m_step == 2) begin c.srca = 1; c.srcb = 2'b10; end
                else begin c.mreq = 1; c.mwr = 1; c.iord = 1; end
        C_BEQ:  begin c.srca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcen = Zero; end
        default: begin c.pcsrc = 2'b10; c.pcen = 1; end
      endcase
    end
    return c;
  endfunction

  // Advance the model on each rising edge using the inputs present at that edge
  always @(posedge CLK) begin
    ctl_t w;
    if (RST) begin
      m_valid = 1; m_rst = 1; m_fault = 0; m_code = 0; m_wait = 0; m_step = 0;
    end else if (m_valid && m_rst) begin
      m_rst = 0; m_step = 0; m_wait = 0;
    end else if (m_valid && !m_fault) begin
      w = model_out();
      if (w.mreq && !MemReady) begin
        if (m_wait + 1 == MEM_TIMEOUT) begin
          m_fault = 1; m_code = 2'b10;
        end else begin
          m_wait++;
        end
      end else if (m_step == 1) begin
        m_step = 2;
        case (Op)
          OP_R:         m_cls = C_R;
          OP_ADDI:      m_cls = C_ADDI;
          OP_LW:        m_cls = C_LW;
          OP_SW:        m_cls = C_SW;
          OP_BEQ:       m_cls = C_BEQ;
          OP_J:         m_cls = C_J;
          default: begin m_fault = 1; m_code = 2'b01; end
        endcase
      end else begin
        m_wait = 0;
        m_step++;
        if (m_step >= instr_len(m_cls)) m_step = 0;
      end
    end
  end

  // Compare every output against the model on every falling edge
  always @(negedge CLK) begin
    ctl_t e;
    if (m_valid) begin
      e = model_out();
      n_checks++;
      if (dut_c !== e) begin
        n_errors++;
        $display("FAIL model_cmp cycle %0d: got %05h expected %05h", cycle_no, dut_c, e);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic lit(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle_no, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, return at the falling edge
  task automatic cyc(input logic rst, input logic [5:0] op, input logic z, input logic rdy);
    @(posedge CLK);
    #1;
    RST = rst; Op = op; Zero = z; MemReady = rdy;
    cycle_no++;
    @(negedge CLK);
  endtask

  int irw_cnt, pcen_cnt, cnt, bad;

  initial begin
    RST = 1'b1; Op = OP_R; Zero = 1'b0; MemReady = 1'b1;

    // 1: reset for two edges, then R-type with MemReady tied high
    cyc(1, OP_R, 0, 1);
    cyc(0, OP_R, 0, 1);                       // S_RESET
    lit("reset_all_zero", int'(dut_c), 0);
    cyc(0, OP_R, 0, 1);                       // FETCH
    lit("r_fetch_irwrite", int'(IRWrite), 1);
    cyc(0, OP_R, 0, 1);                       // DECODE
    cyc(0, OP_R, 0, 1);                       // RTYPE
    lit("r_aluop", int'(ALUOp), 2);
    cyc(0, OP_R, 0, 1);                       // ALUWB
    lit("r_wb_regw_regdst", int'({RegWrite, RegDst}), 3);

    // 2: LW with three wait cycles in FETCH and in MEMRD
    irw_cnt = 0; pcen_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, OP_LW, 0, (i == 3));
      irw_cnt += int'(IRWrite); pcen_cnt += int'(PCEn);
    end
    lit("lw_irw_pulses", irw_cnt, 1);
    lit("lw_pcen_pulses", pcen_cnt, 1);
    cyc(0, OP_LW, 0, 0);                      // DECODE
    cyc(0, OP_LW, 0, 0);                      // MEMADR
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, OP_LW, 0, (i == 3));
      cnt += int'(RegWrite);
    end
    lit("lw_no_early_regw", cnt, 0);
    cyc(0, OP_LW, 0, 0);                      // MEMWB
    lit("lw_wb_regw_m2r", int'({RegWrite, MemtoReg}), 3);
    lit("lw_no_fault", int'(Fault), 0);

    // 3: BEQ taken, then not taken
    cyc(0, OP_BEQ, 0, 1);                     // FETCH
    cyc(0, OP_BEQ, 0, 1);                     // DECODE
    cyc(0, OP_BEQ, 1, 0);                     // BEQ, Zero=1
    lit("beq_taken_pcen", int'(PCEn), 1);
    lit("beq_pcsrc", int'(PCSrc), 1);
    cyc(0, OP_BEQ, 0, 1);                     // FETCH
    cyc(0, OP_BEQ, 0, 1);                     // DECODE
    cyc(0, OP_BEQ, 0, 0);                     // BEQ, Zero=0
    lit("beq_not_taken_pcen", int'(PCEn), 0);

    // 4: SW with MemReady stuck low -> bus timeout
    cyc(0, OP_SW, 0, 1);                      // FETCH
    lit("beq_back_to_fetch", int'(MemReq), 1);
    cyc(0, OP_SW, 0, 0);                      // DECODE
    cyc(0, OP_SW, 0, 0);                      // MEMADR
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, OP_SW, 0, 0);
      cnt += int'(MemWrite);
    end
    lit("sw_memwrite_cycles", cnt, 15);
    lit("sw_fault", int'(Fault), 1);
    lit("sw_fault_code", int'(FaultCode), 2);
    lit("sw_fault_no_memreq", int'(MemReq), 0);

    // 5: illegal opcode
    cyc(1, OP_BAD, 0, 1);
    cyc(0, OP_BAD, 0, 1);                     // S_RESET
    lit("rst_clears_fault", int'(Fault), 0);
    cyc(0, OP_BAD, 0, 1);                     // FETCH
    cyc(0, OP_BAD, 0, 1);                     // DECODE
    lit("bad_decode_srcb", int'(ALUSrcB), 3);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, OP_BAD, 0, 1);
      bad |= int'(RegWrite | MemReq | PCEn);
    end
    lit("bad_fault_code", int'(FaultCode), 1);
    lit("bad_quiet_outputs", bad, 0);

    // 6: reset in the middle of a MEMRD wait, then clean ADDI and J
    cyc(1, OP_LW, 0, 1);
    cyc(0, OP_LW, 0, 1);                      // S_RESET
    cyc(0, OP_LW, 0, 1);                      // FETCH
    cyc(0, OP_LW, 0, 0);                      // DECODE
    cyc(0, OP_LW, 0, 0);                      // MEMADR
    cyc(0, OP_LW, 0, 0);                      // MEMRD wait
    cyc(1, OP_LW, 0, 0);                      // MEMRD wait, reset at its end
    cyc(0, OP_ADDI, 0, 0);                    // S_RESET
    lit("midwait_reset_zero", int'(dut_c), 0);
    irw_cnt = 0;
    for (int i = 0; i < 15; i++) begin         // 14 waits, ready on the limit cycle
      cyc(0, OP_ADDI, 0, (i == 14));
      irw_cnt += int'(IRWrite);
    end
    lit("limit_ready_wins", irw_cnt, 1);
    lit("limit_no_fault", int'(Fault), 0);
    cyc(0, OP_ADDI, 0, 1);                    // DECODE
    cyc(0, OP_ADDI, 0, 1);                    // ADDIEX
    lit("addi_srcb", int'(ALUSrcB), 2);
    cyc(0, OP_J, 0, 1);                       // ADDIWB
    lit("addi_wb", int'({RegWrite, RegDst, MemtoReg}), 4);
    cyc(0, OP_J, 0, 1);                       // FETCH
    cyc(0, OP_J, 0, 1);                       // DECODE
    cyc(0, OP_J, 0, 1);                       // JUMP
    lit("j_pcen_pcsrc", int'({PCEn, PCSrc}), 6);
    cyc(0, OP_R, 0, 1);                       // FETCH
    lit("j_back_to_fetch", int'(MemReq), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
